// File: rtl/wb_pkg.sv
// Shared definitions for the 8-bit Wishbone byte master: FSM encoding and bus widths.
package wb_pkg;

  localparam int WB_DW         = 8;
  localparam int WB_AW_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_byte_master.sv
// Wishbone classic-cycle master: one command in, one single-beat bus transaction,
// one response out, with a guaranteed idle cycle between strobes and a bounded ACK wait.
module wb_byte_master
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_adr,
  input  logic [WB_DW-1:0] cmd_dat,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_dat,
  output logic             rsp_err,
  output logic [AW-1:0]    WB_ADRo,
  output logic [WB_DW-1:0] WB_DATo,
  input  logic [WB_DW-1:0] WB_DATi,
  output logic             WB_WEo,
  output logic             WB_CYCo,
  output logic             WB_STBo,
  input  logic             WB_ACKi
);

  // The counter stays at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  wb_state_t        r_state;
  wb_state_t        w_next;
  logic [AW-1:0]    r_adr;
  logic [WB_DW-1:0] r_dat;
  logic             r_we;
  logic [CW-1:0]    r_cnt;
  logic [WB_DW-1:0] r_rsp_dat;
  logic             r_rsp_err;
  logic             w_accept;
  logic             w_timeout;

  assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (cmd_valid)            w_next = ST_BUS;
      ST_BUS:  if (WB_ACKi || w_timeout) w_next = ST_RESP;
      ST_RESP: if (rsp_ready)            w_next = ST_IDLE;
      default:                           w_next = ST_IDLE;
    endcase
  end

  // Handshake and strobe outputs decode the state only, so reset drops CYC/STB at once.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    WB_CYCo   = 1'b0;
    WB_STBo   = 1'b0;
    unique case (r_state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_BUS: begin
        WB_CYCo = 1'b1;
        WB_STBo = 1'b1;
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adr     <= '0;
      r_dat     <= '0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else if (w_accept) begin
      r_adr <= cmd_adr;
      r_dat <= cmd_dat;
      r_we  <= cmd_we;
      r_cnt <= '0;
    end else if (r_state == ST_BUS) begin
      if (WB_ACKi) begin
        r_rsp_dat <= r_we ? '0 : WB_DATi;
        r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_dat <= '0;
        r_rsp_err <= 1'b1;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign WB_ADRo = r_adr;
  assign WB_DATo = r_dat;
  assign WB_WEo  = r_we;
  assign rsp_dat = r_rsp_dat;
  assign rsp_err = r_rsp_err;

endmodule

// File: tb/tb_wb_byte_master.sv
// Self-checking bench for wb_byte_master: RAM slave with a registered STB&CYC ACK,
// directed vectors, bus-protocol corner cases and randomized traffic against a memory model.
module tb_wb_byte_master;
  import wb_pkg::*;

  localparam int AW = 10;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [7:0]    dat;
    logic [7:0]    exp_dat;
  } vec_t;

  bit clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main DUT (TIMEOUT = 15) signals
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [7:0]    cmd_dat;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [7:0]    rsp_dat;
  logic [AW-1:0] WB_ADRo;
  logic [7:0]    WB_DATo, WB_DATi;
  logic          WB_WEo, WB_CYCo, WB_STBo, WB_ACKi;

  // Second DUT (TIMEOUT = 0) signals
  logic          c0_valid, c0_ready, c0_we;
  logic [AW-1:0] c0_adr;
  logic [7:0]    c0_dat;
  logic          r0_valid, r0_ready, r0_err;
  logic [7:0]    r0_dat;
  logic [AW-1:0] b0_adr;
  logic [7:0]    b0_dato, b0_dati;
  logic          b0_we, b0_cyc, b0_stb, b0_ack;

  wb_byte_master #(.AW(AW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .WB_ADRo(WB_ADRo), .WB_DATo(WB_DATo), .WB_DATi(WB_DATi), .WB_WEo(WB_WEo),
    .WB_CYCo(WB_CYCo), .WB_STBo(WB_STBo), .WB_ACKi(WB_ACKi)
  );

  wb_byte_master #(.AW(AW), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_we(c0_we),
    .cmd_adr(c0_adr), .cmd_dat(c0_dat),
    .rsp_valid(r0_valid), .rsp_ready(r0_ready), .rsp_dat(r0_dat), .rsp_err(r0_err),
    .WB_ADRo(b0_adr), .WB_DATo(b0_dato), .WB_DATi(b0_dati), .WB_WEo(b0_we),
    .WB_CYCo(b0_cyc), .WB_STBo(b0_stb), .WB_ACKi(b0_ack)
  );

  // RAM slave: ACK is STB&CYC gated by last cycle's registered STB&CYC.
  logic [7:0] s_mem [0:1023];
  bit         s_stb_q = 1'b0;
  bit         s_mute  = 1'b0;
  assign WB_ACKi = WB_CYCo && WB_STBo && s_stb_q && !s_mute;
  assign WB_DATi = s_mem[WB_ADRo];
  always @(posedge clk) begin
    s_stb_q <= WB_CYCo && WB_STBo;
    if (WB_ACKi && WB_WEo) s_mem[WB_ADRo] <= WB_DATo;
  end

  // Slow slave for the TIMEOUT = 0 instance: ACK in the 41st strobe cycle.
  int s0_cnt = 0;
  assign b0_ack  = b0_cyc && b0_stb && (s0_cnt == 40);
  assign b0_dati = 8'h3C;
  always @(posedge clk) s0_cnt <= (b0_cyc && b0_stb) ? s0_cnt + 1 : 0;

  // Protocol monitor on the main bus
  int  b2b_viol = 0, spur_ack = 0;
  bit  m_prev_stb = 1'b0, m_prev_ack = 1'b0;
  always @(negedge clk) begin
    if (WB_STBo && m_prev_ack)                 b2b_viol++;
    if (WB_ACKi && WB_STBo && !m_prev_stb)     spur_ack++;
    m_prev_stb = WB_STBo;
    m_prev_ack = WB_ACKi;
  end

  // Reference memory: what every address should hold after the writes so far.
  logic [7:0] ref_mem [0:1023];

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on the main DUT and collect its response. bp = cycles of
  // held-off rsp_ready once the response shows up; stable reports whether the
  // response held still and cmd_ready stayed low during that time.
  task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input logic [7:0] dat,
                         input int bp, output int lat, output int stb_cyc,
                         output logic [7:0] got_dat, output logic got_err,
                         output bit ok, output bit stable);
    int n;
    ok = 1'b1; stable = 1'b1; lat = -1; stb_cyc = 0; got_dat = '0; got_err = 1'b0;
    rsp_ready = (bp == 0);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (!cmd_ready) begin ok = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1; return; end
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      if (WB_STBo) stb_cyc++;
      tick();
      lat++;
    end
    if (!rsp_valid) begin ok = 1'b0; rsp_ready = 1'b1; return; end
    got_dat = rsp_dat;
    got_err = rsp_err;
    for (int k = 0; k < bp; k++) begin
      tick();
      if (!rsp_valid || rsp_dat !== got_dat || rsp_err !== got_err || cmd_ready) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [8];
    int         lat, stb_cyc, n, acc;
    logic [7:0] gd, exp_d;
    logic       ge, r_we;
    logic [AW-1:0] r_adr;
    logic [7:0] r_dat;
    bit         ok, stable;

    for (int i = 0; i < 1024; i++) begin
      s_mem[i]   = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end

    rst = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; rsp_ready = 1'b1;
    c0_valid = 1'b0; c0_we = 1'b0; c0_adr = '0; c0_dat = '0; r0_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("reset cmd_ready", cmd_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_dat", rsp_dat, 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset cyc/stb/we", {WB_CYCo, WB_STBo, WB_WEo}, 0);
    check("reset adr", WB_ADRo, 0);
    check("reset dat", WB_DATo, 0);
    check("reset t0 cmd_ready/rsp_valid", {c0_ready, r0_valid, b0_stb}, 3'b100);
    rst = 1'b1;
    tick();

    // Directed vectors: write then read, latency 3, two strobe cycles each
    vecs[0] = '{1'b1, 10'h3FF, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 10'h3FF, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 10'h000, 8'h5A, 8'h00};
    vecs[3] = '{1'b0, 10'h000, 8'hFF, 8'h5A};
    vecs[4] = '{1'b0, 10'h010, 8'h00, 8'h73};
    vecs[5] = '{1'b1, 10'h155, 8'hFF, 8'h00};
    vecs[6] = '{1'b0, 10'h155, 8'h00, 8'hFF};
    vecs[7] = '{1'b0, 10'h2AA, 8'h00, 8'hA9};
    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].we, vecs[i].adr, vecs[i].dat, 0, lat, stb_cyc, gd, ge, ok, stable);
      if (vecs[i].we) ref_mem[vecs[i].adr] = vecs[i].dat;
      check($sformatf("vec%0d completed", i), ok, 1);
      check($sformatf("vec%0d rsp_dat", i), gd, vecs[i].exp_dat);
      check($sformatf("vec%0d rsp_err", i), ge, 0);
      check($sformatf("vec%0d latency", i), lat, 3);
      check($sformatf("vec%0d stb cycles", i), stb_cyc, 2);
    end

    // Back-to-back with cmd_valid held high: one accept every 4 cycles
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 10'h3FF; rsp_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (cmd_ready && rsp_valid) acc += 100;
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    check("b2b accepts in 8 cycles", acc, 2);
    check("b2b stb gap", b2b_viol, 0);
    check("b2b spurious ack", spur_ack, 0);

    // Missing ACK: STB high exactly 15 cycles, error response, then recovery
    s_mute = 1'b1;
    run_cmd(1'b0, 10'h3FF, 8'h00, 0, lat, stb_cyc, gd, ge, ok, stable);
    s_mute = 1'b0;
    check("timeout completed", ok, 1);
    check("timeout stb cycles", stb_cyc, 15);
    check("timeout latency", lat, 16);
    check("timeout rsp_err", ge, 1);
    check("timeout rsp_dat", gd, 0);
    check("timeout bus idle after", {WB_CYCo, WB_STBo}, 0);
    run_cmd(1'b0, 10'h3FF, 8'h00, 0, lat, stb_cyc, gd, ge, ok, stable);
    check("post-timeout rsp_dat", gd, 8'hA5);
    check("post-timeout rsp_err", ge, 0);
    check("post-timeout latency", lat, 3);

    // Response backpressure with another command waiting
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 10'h000;
    tick();
    cmd_adr = 10'h155;
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check("bp response arrived", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp c%0d rsp_valid", i), rsp_valid, 1);
      check($sformatf("bp c%0d rsp_dat", i), rsp_dat, 8'h5A);
      check($sformatf("bp c%0d cmd_ready", i), cmd_ready, 0);
      check($sformatf("bp c%0d bus idle", i), {WB_CYCo, WB_STBo}, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp released cmd_ready", cmd_ready, 1);
    check("bp released rsp_valid", rsp_valid, 0);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check("bp held cmd rsp_dat", rsp_dat, 8'hFF);
    tick();

    // Reset asserted in BUS: strobe falls without a clock edge
    s_mute = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 10'h001; cmd_dat = 8'h11;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre-reset stb", WB_STBo, 1);
    #2 rst = 1'b0;
    #1;
    check("async reset cyc/stb", {WB_CYCo, WB_STBo}, 0);
    #2 rst = 1'b1;
    s_mute = 1'b0;
    tick();
    check("after reset cmd_ready", cmd_ready, 1);
    check("after reset rsp_valid", rsp_valid, 0);
    tick();
    check("after reset no response", rsp_valid, 0);

    // TIMEOUT = 0 instance: slave answers after 40 wait cycles, no abort
    c0_valid = 1'b1; c0_we = 1'b0; c0_adr = 10'h005;
    tick();
    c0_valid = 1'b0;
    lat = 1; stb_cyc = 0;
    while (!r0_valid && lat < 200) begin
      if (b0_stb) stb_cyc++;
      tick();
      lat++;
    end
    check("t0 stb cycles", stb_cyc, 41);
    check("t0 latency", lat, 42);
    check("t0 rsp_err", r0_err, 0);
    check("t0 rsp_dat", r0_dat, 8'h3C);
    tick();

    // Randomized traffic with random response backpressure
    for (int i = 0; i < 150; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_adr = ($urandom_range(0, 1) != 0 ? 10'h3E0 : 10'h000) | 10'($urandom_range(0, 31));
      r_dat = 8'($urandom);
      run_cmd(r_we, r_adr, r_dat, int'($urandom_range(0, 3)), lat, stb_cyc, gd, ge, ok, stable);
      if (r_we) begin
        exp_d = 8'h00;
        ref_mem[r_adr] = r_dat;
      end else begin
        exp_d = ref_mem[r_adr];
      end
      check($sformatf("rnd%0d ok", i), {ok, stable}, 2'b11);
      check($sformatf("rnd%0d rsp_dat adr=%0h we=%0b", i, r_adr, r_we), gd, exp_d);
      check($sformatf("rnd%0d rsp_err", i), ge, 0);
      check($sformatf("rnd%0d latency", i), lat, 3);
    end
    check("final stb gap", b2b_viol, 0);
    check("final spurious ack", spur_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
